md_sched: RTL and testbench

Multiply/divide scheduler for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and sequences multi-cycle operations with a busy counter. Owns the HI/LO registers. Tells the ID stage to stall any HI/LO-class instruction while an operation is in flight. Sits beside the EX-stage ALU; its HI/LO outputs feed the MFHI/MFLO result mux.

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_arith.sv | 68 ++++++
 rtl/md_sched.sv | 129 ++++++++++++
 tb/tb_md_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: md_op encodings,
// default operation latencies and the scheduler state type.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // True for the multi-cycle operations that occupy the scheduler.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational MIPS multiply/divide datapath: signed/unsigned products and
// quotient/remainder with the divide-by-zero and signed-overflow rules.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_we
);

    logic [63:0]        prod_s;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    // Operation select; a zero divisor suppresses the HI/LO write.
    always_comb begin
        res_hi = 32'h0000_0000;
        res_lo = 32'h0000_0000;
        res_we = 1'b0;
        a_s    = $signed(a);
        b_s    = $signed(b);
        prod_s = 64'h0;
        case (op)
            MD_MULT: begin
                // Product of sign-extended operands, modulo 2^64, is the signed product.
                prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_we = 1'b1;
            end
            MD_MULTU: begin
                prod_s = {32'h0000_0000, a} * {32'h0000_0000, b};
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_we = 1'b1;
            end
            MD_DIV: begin
                if (b == 32'h0000_0000) begin
                    res_we = 1'b0;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'h0000_0000;
                    res_we = 1'b1;
                end else begin
                    res_lo = a_s / b_s;
                    res_hi = a_s % b_s;
                    res_we = 1'b1;
                end
            end
            MD_DIVU: begin
                if (b == 32'h0000_0000) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                    res_we = 1'b1;
                end
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO owner for the MIPS pipeline: sequences multi-cycle MULT/DIV with a
// busy counter and stalls HI/LO-class instructions in ID while one is in flight.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        md_in_id,
    output logic        busy,
    output logic        stall_id,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_we_q, pend_we_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;

    logic          accept_s;
    logic [31:0]   ar_hi_s;
    logic [31:0]   ar_lo_s;
    logic          ar_we_s;

    md_arith u_arith (
        .op     (md_op),
        .a      (src_a),
        .b      (src_b),
        .res_hi (ar_hi_s),
        .res_lo (ar_lo_s),
        .res_we (ar_we_s)
    );

    // Next-state: accept in IDLE, count down in RUN, retire pending into HI/LO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        accept_s  = start & ~flush & (state_q == S_IDLE) & (md_op != MD_NONE);
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (md_op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            pend_hi_d = ar_hi_s;
                            pend_lo_d = ar_lo_s;
                            pend_we_d = ar_we_s;
                            cnt_d     = is_muldiv(md_op) && ((md_op == MD_DIV) || (md_op == MD_DIVU))
                                        ? DIV_LOAD : MULT_LOAD;
                            state_d   = S_RUN;
                        end
                        MD_MTHI: hi_d = src_a;
                        MD_MTLO: lo_d = src_a;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // flush and start are ignored here: the in-flight op has already committed.
                if (cnt_q == {CW{1'b0}}) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            pend_hi_q <= 32'h0000_0000;
            pend_lo_q <= 32'h0000_0000;
            pend_we_q <= 1'b0;
            hi_q      <= 32'h0000_0000;
            lo_q      <= 32'h0000_0000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_id = md_in_id & (busy_q | (start & is_muldiv(md_op) & ~flush));

endmodule

// File: tb/tb_md_sched.sv
// Randomized self-checking bench for md_sched against a cycle-count/arithmetic
// reference model, plus directed corner cases.
module tb_md_sched;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        md_in_id;
    logic        busy;
    logic        stall_id;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .md_in_id (md_in_id),
        .busy     (busy),
        .stall_id (stall_id),
        .hi       (hi),
        .lo       (lo)
    );

    int errs   = 0;
    int checks = 0;

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_we;
    int          m_rem;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p_we = 1'b1;
        case (op)
            MD_MULT:  begin q = sa * sb; p_hi = q[63:32]; p_lo = q[31:0]; end
            MD_MULTU: begin uq = ua * ub; p_hi = uq[63:32]; p_lo = uq[31:0]; end
            MD_DIV: begin
                if (b == 32'h0) p_we = 1'b0;
                else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
            end
            MD_DIVU: begin
                if (b == 32'h0) p_we = 1'b0;
                else begin uq = ua / ub; ur = ua % ub; p_lo = uq[31:0]; p_hi = ur[31:0]; end
            end
            default: p_we = 1'b0;
        endcase
    endtask

    // One pipeline cycle: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic f, input logic id);
        logic exp_busy, exp_stall;
        start = s; md_op = op; src_a = a; src_b = b; flush = f; md_in_id = id;
        @(negedge clk);
        exp_busy  = (m_rem > 0);
        exp_stall = id & (exp_busy | (s & (op >= 3'd1) & (op <= 3'd4) & ~f));
        check_val("busy", {31'b0, busy}, {31'b0, exp_busy});
        check_val("stall_id", {31'b0, stall_id}, {31'b0, exp_stall});
        check_val("hi", hi, m_hi);
        check_val("lo", lo, m_lo);
        @(posedge clk);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_we) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (s && !f && op != 3'd0) begin
            if (op == 3'd1 || op == 3'd2) begin model_compute(op, a, b); m_rem = MC; end
            else if (op == 3'd3 || op == 3'd4) begin model_compute(op, a, b); m_rem = DC; end
            else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic id);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, id);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] saved_hi, saved_lo;

    initial begin
        m_hi = 32'h0; m_lo = 32'h0; p_hi = 32'h0; p_lo = 32'h0; p_we = 1'b0; m_rem = 0;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'h0; src_b = 32'h0;
        flush = 1'b0; md_in_id = 1'b0;
        #12;
        check_val("rst_busy", {31'b0, busy}, 32'h0);
        check_val("rst_stall", {31'b0, stall_id}, 32'h0);
        check_val("rst_hi", hi, 32'h0);
        check_val("rst_lo", lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Signed MULT with ID stall window
        cyc(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
        idle(5, 1'b1);
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFF1);

        // Signed DIV -7/2
        cyc(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        check_val("div_hi", hi, 32'hFFFF_FFFF);

        // Flush blocks both multi-cycle and MTLO
        saved_hi = m_hi; saved_lo = m_lo;
        cyc(1'b1, MD_MULT, 32'd7, 32'd9, 1'b1, 1'b0);
        idle(2, 1'b0);
        check_val("flush_busy", {31'b0, busy}, 32'h0);
        check_val("flush_hi", hi, saved_hi);
        cyc(1'b1, MD_MTLO, 32'h1234, 32'h0, 1'b1, 1'b0);
        idle(1, 1'b0);
        check_val("flush_mtlo", lo, saved_lo);

        // DIVU by zero leaves HI/LO intact
        cyc(1'b1, MD_MTHI, 32'hAA, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, MD_MTLO, 32'hBB, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, MD_DIVU, 32'd55, 32'h0, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        check_val("dz_hi", hi, 32'hAA);
        check_val("dz_lo", lo, 32'hBB);

        // Signed overflow divide
        cyc(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        check_val("ovf_lo", lo, 32'h8000_0000);
        check_val("ovf_hi", hi, 32'h0);

        // Reset during the 4th busy cycle of a DIV
        cyc(1'b1, MD_MTHI, 32'h5555, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(3, 1'b0);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_busy", {31'b0, busy}, 32'h0);
        check_val("mid_rst_hi", hi, 32'h0);
        check_val("mid_rst_lo", lo, 32'h0);
        m_hi = 32'h0; m_lo = 32'h0; m_rem = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MC + 1, 1'b0);
        check_val("multu_hi", hi, 32'h1);
        check_val("multu_lo", lo, 32'hFFFF_FFFE);

        // Random traffic including start-while-busy and flush
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick(), pick(),
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
